// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V controller and the immediate generator.
// The imm_sel codes here are the contract between the two blocks.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;
  typedef enum logic [1:0] {PC_PLUS4, PC_BRANCH, PC_JAL} pc_src_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_e;
  typedef enum logic [1:0] {FLT_NONE, FLT_ILLEGAL, FLT_TIMEOUT, FLT_EBREAK} fault_e;

  typedef enum logic [2:0] {
    CLS_OP, CLS_OPIMM, CLS_LUI, CLS_JAL, CLS_BRANCH, CLS_LOAD, CLS_STORE, CLS_EBREAK
  } cls_e;

  // alt selects SUB/SRA; callers decide when funct7[5] is meaningful.
  function automatic alu_op_e alu_dec(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/riscv_ctrl_decode.sv
// Combinational IR decoder: instruction class, ALU op, immediate format and legality.
module riscv_ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output cls_e        cls_o,
  output alu_op_e     alu_op_o,
  output imm_sel_e    imm_sel_o,
  output logic        illegal_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_bits;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];
  assign unused_bits = ^{instr_i[11:7], instr_i[19:15], instr_i[24:21]};

  always_comb begin
    cls_o     = CLS_OP;
    alu_op_o  = ALU_ADD;
    imm_sel_o = IMM_I;
    illegal_o = 1'b0;
    case (opc)
      OPC_LUI:    begin cls_o = CLS_LUI; imm_sel_o = IMM_U; end
      OPC_JAL:    begin cls_o = CLS_JAL; imm_sel_o = IMM_J; end
      OPC_BRANCH: begin
        cls_o     = CLS_BRANCH;
        imm_sel_o = IMM_B;
        alu_op_o  = ALU_SUB;
        illegal_o = (f3[2:1] != 2'b00);
      end
      OPC_LOAD:   cls_o = CLS_LOAD;
      OPC_STORE:  begin cls_o = CLS_STORE; imm_sel_o = IMM_S; end
      OPC_OPIMM:  begin
        cls_o    = CLS_OPIMM;
        alu_op_o = alu_dec(f3, (f3 == 3'b101) && f7[5]);
      end
      OPC_OP:     begin
        cls_o     = CLS_OP;
        alu_op_o  = alu_dec(f3, f7[5]);
        illegal_o = !((f7 == 7'b0000000) ||
                      ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      // Only EBREAK is supported from the SYSTEM space; ECALL is treated as illegal.
      OPC_SYSTEM: begin cls_o = CLS_EBREAK; illegal_o = !instr_i[20]; end
      default:    illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I-subset controller: FSM, memory wait/timeout counter and retire counter.
// Strobes are decoded combinationally from the current state and the held IR.
module riscv_multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned INSTRET_W   = 32
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic [31:0]          instruction,
  input  logic                 alu_zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic                 alu_src_b,
  output logic [3:0]           alu_op,
  output logic [2:0]           imm_sel,
  output logic                 halted,
  output logic [1:0]           fault,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  state_e               state_q, state_d;
  fault_e               fault_q, fault_d;
  logic [7:0]           wait_q, wait_d;
  logic [INSTRET_W-1:0] instret_q;
  logic                 retire, timeout, taken, in_mem_phase;

  cls_e     dec_cls;
  alu_op_e  dec_alu_op;
  imm_sel_e dec_imm_sel;
  logic     dec_illegal;

  riscv_ctrl_decode u_decode (
    .instr_i   (instruction),
    .cls_o     (dec_cls),
    .alu_op_o  (dec_alu_op),
    .imm_sel_o (dec_imm_sel),
    .illegal_o (dec_illegal)
  );

  assign in_mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
  // A ready arriving in the final allowed cycle still completes the transfer.
  assign timeout = !mem_ready && (wait_q == 8'(MEM_TIMEOUT - 1));
  assign taken   = instruction[12] ? !alu_zero : alu_zero;

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) begin state_d = S_HALT; fault_d = FLT_TIMEOUT; end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          state_d = S_HALT; fault_d = FLT_ILLEGAL;
        end else if (dec_cls == CLS_EBREAK) begin
          state_d = S_HALT; fault_d = FLT_EBREAK; retire = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:   begin
        case (dec_cls)
          CLS_BRANCH, CLS_JAL, CLS_LUI: begin state_d = S_FETCH; retire = 1'b1; end
          CLS_LOAD, CLS_STORE:          state_d = S_MEM;
          default:                      state_d = S_WB;
        endcase
      end
      S_MEM:    begin
        if (mem_ready) begin
          if (dec_cls == CLS_STORE) begin state_d = S_FETCH; retire = 1'b1; end
          else                            state_d = S_WB;
        end else if (timeout) begin
          state_d = S_HALT; fault_d = FLT_TIMEOUT;
        end
      end
      S_WB:     begin state_d = S_FETCH; retire = 1'b1; end
      default:  state_d = S_HALT;
    endcase

    wait_d = wait_q;
    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM)))
      wait_d = 8'd0;
    else if (in_mem_phase && !mem_ready)
      wait_d = wait_q + 8'd1;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      fault_q   <= FLT_NONE;
      wait_q    <= 8'd0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      wait_q  <= wait_d;
      if (retire) instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_PLUS4;
    reg_write    = 1'b0;
    wb_sel       = WB_ALU;
    alu_src_b    = 1'b0;
    alu_op       = ALU_ADD;
    imm_sel      = IMM_I;
    if ((state_q == S_DECODE) || (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
      imm_sel   = dec_imm_sel;
      alu_op    = dec_alu_op;
      alu_src_b = !((dec_cls == CLS_OP) || (dec_cls == CLS_BRANCH));
    end
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
      end
      S_EXEC: begin
        case (dec_cls)
          CLS_BRANCH: begin pc_write = 1'b1; pc_src = taken ? PC_BRANCH : PC_PLUS4; end
          CLS_JAL:    begin pc_write = 1'b1; pc_src = PC_JAL; reg_write = 1'b1; wb_sel = WB_PC4; end
          CLS_LUI:    begin pc_write = 1'b1; reg_write = 1'b1; wb_sel = WB_IMM; end
          default:    ;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (dec_cls == CLS_STORE);
        pc_write     = mem_ready && (dec_cls == CLS_STORE);
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (dec_cls == CLS_LOAD) ? WB_MEM : WB_ALU;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign halted  = (state_q == S_HALT);
  assign fault   = fault_q;
  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl with hand-computed expectations.
module tb_riscv_multicycle_ctrl;
  import riscv_ctrl_pkg::*;

  logic        sysclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction = '0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write, alu_src_b, halted;
  logic [1:0]  pc_src, wb_sel, fault;
  logic [3:0]  alu_op;
  logic [2:0]  imm_sel, state;
  logic [31:0] instret;

  int vectors = 0, miscompares = 0, ncyc = 0, c0 = 0;

  riscv_multicycle_ctrl #(.MEM_TIMEOUT(15), .INSTRET_W(32)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .instruction(instruction), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .wb_sel(wb_sel), .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_sel(imm_sel),
    .halted(halted), .fault(fault), .state(state), .instret(instret)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk); #2;
    ncyc++;
  endtask

  // Presents the instruction with a zero-wait fetch; returns in DECODE.
  task automatic fetch(input logic [31:0] ir);
    instruction = ir;
    mem_ready   = 1'b1;
    #1;
    chk("fetch_state", state, S_FETCH);
    chk("fetch_req", {mem_req, mem_we, mem_addr_sel, ir_write}, 4'b1001);
    step();
    mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_state", state, S_IDLE);
    chk("rst_outs", {mem_req, mem_we, pc_write, reg_write, halted, fault}, 7'b0);
    chk("rst_instret", instret, 0);
    step();
    rst_n = 1'b1;
    #1 chk("rst_idle", state, S_IDLE);
    step();
    #1 chk("rst_to_fetch", state, S_FETCH);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    step();
    #1;
    chk("init_state", state, S_IDLE);
    chk("init_outs", {mem_req, ir_write, pc_write, reg_write, halted, fault}, 7'b0);
    chk("init_instret", instret, 0);
    step();
    rst_n = 1'b1;
    #1 chk("init_idle", state, S_IDLE);
    step();
    #1 chk("init_fetch", state, S_FETCH);

    // addi x5,x0,42
    c0 = ncyc;
    fetch(32'h02a00293);
    #1 chk("addi_dec", state, S_DECODE);
    chk("addi_imm", {imm_sel, alu_src_b}, {3'd0, 1'b1});
    step(); #1 chk("addi_exec", {state, alu_op, reg_write}, {S_EXEC, 4'd0, 1'b0});
    step(); #1 chk("addi_wb", {state, reg_write, wb_sel, pc_write, pc_src}, {S_WB, 1'b1, 2'd0, 1'b1, 2'd0});
    chk("addi_instret_pre", instret, 0);
    step(); #1 chk("addi_done", state, S_FETCH);
    chk("addi_instret", instret, 1);
    chk("addi_cycles", ncyc - c0, 4);

    // lw x5,0(x10) with two memory wait states
    c0 = ncyc;
    fetch(32'h00052283);
    step(); #1 chk("lw_exec_alu", alu_op, ALU_ADD);
    step(); #1 chk("lw_mem1", {state, mem_req, mem_addr_sel, mem_we}, {S_MEM, 3'b110});
    step(); #1 chk("lw_mem2", {state, mem_req, mem_addr_sel, mem_we}, {S_MEM, 3'b110});
    step(); mem_ready = 1'b1;
    #1 chk("lw_mem3", {state, mem_req, mem_addr_sel, mem_we, pc_write}, {S_MEM, 4'b1100});
    step(); mem_ready = 1'b0;
    #1 chk("lw_wb", {state, wb_sel, reg_write}, {S_WB, 2'd1, 1'b1});
    step(); #1 chk("lw_instret", instret, 2);
    chk("lw_cycles", ncyc - c0, 7);

    // beq taken then not taken
    fetch(32'h01c38463);
    #1 chk("beq_dec", {imm_sel, alu_src_b}, {3'd2, 1'b0});
    step(); alu_zero = 1'b1;
    #1 chk("beq_t_exec", {pc_write, pc_src, reg_write, alu_op}, {1'b1, 2'd1, 1'b0, 4'd1});
    step(); #1 chk("beq_t_done", {state, instret}, {S_FETCH, 32'd3});
    fetch(32'h01c38463);
    step(); alu_zero = 1'b0;
    #1 chk("beq_nt_exec", {pc_write, pc_src, reg_write}, {1'b1, 2'd0, 1'b0});
    step(); #1 chk("beq_nt_done", {state, instret}, {S_FETCH, 32'd4});

    // add / sub
    fetch(32'h006283b3);
    #1 chk("add_srcb", alu_src_b, 0);
    step(); #1 chk("add_exec", {state, alu_op}, {S_EXEC, 4'd0});
    step(); #1 chk("add_wb", {state, reg_write, wb_sel}, {S_WB, 1'b1, 2'd0});
    step(); #1 chk("add_instret", instret, 5);
    fetch(32'h406283b3);
    step(); #1 chk("sub_exec", alu_op, ALU_SUB);
    step(); step(); #1 chk("sub_instret", instret, 6);

    // lui / jal
    fetch(32'h123452b7);
    step(); #1 chk("lui_exec", {reg_write, wb_sel, imm_sel, pc_write, pc_src}, {1'b1, 2'd3, 3'd3, 1'b1, 2'd0});
    step(); #1 chk("lui_done", {state, instret}, {S_FETCH, 32'd7});
    fetch(32'h008000ef);
    step(); #1 chk("jal_exec", {pc_src, wb_sel, imm_sel, reg_write, pc_write}, {2'd2, 2'd2, 3'd4, 1'b1, 1'b1});
    step(); #1 chk("jal_done", {state, instret}, {S_FETCH, 32'd8});

    // sw zero-wait
    c0 = ncyc;
    fetch(32'h00552023);
    #1 chk("sw_imm", imm_sel, IMM_S);
    step(); step(); mem_ready = 1'b1;
    #1 chk("sw_mem", {mem_req, mem_we, mem_addr_sel, pc_write, reg_write}, 5'b11110);
    step(); mem_ready = 1'b0;
    #1 chk("sw_done", {state, instret}, {S_FETCH, 32'd9});
    chk("sw_cycles", ncyc - c0, 4);

    // reset asserted mid-MEM of a store
    fetch(32'h00552023);
    step(); step();
    #1 chk("swr_mem", {state, mem_req, mem_we}, {S_MEM, 2'b11});
    do_reset();

    // EBREAK
    fetch(32'h00100073);
    step(); #1 chk("ebreak_halt", {state, fault, halted}, {S_HALT, 2'd3, 1'b1});
    chk("ebreak_instret", instret, 1);
    do_reset();

    // illegal instruction
    fetch(32'hffffffff);
    step(); #1 chk("ill_halt", {state, fault, halted}, {S_HALT, 2'd1, 1'b1});
    chk("ill_instret", instret, 0);
    mem_ready = 1'b1;
    step(); #1 chk("ill_noreq", {state, mem_req, ir_write}, {S_HALT, 2'b00});
    mem_ready = 1'b0;
    do_reset();

    // ready in the last allowed wait cycle rescues the fetch
    instruction = 32'h02a00293;
    for (int i = 0; i < 14; i++) step();
    #1 chk("rescue_still_fetch", {state, mem_req}, {S_FETCH, 1'b1});
    mem_ready = 1'b1;
    #1 chk("rescue_irw", ir_write, 1);
    step(); mem_ready = 1'b0;
    #1 chk("rescue_dec", {state, fault}, {S_DECODE, 2'd0});
    step(); step(); step();
    #1 chk("rescue_done", {state, instret}, {S_FETCH, 32'd1});

    // fetch timeout after 15 unacknowledged cycles
    for (int i = 0; i < 14; i++) step();
    #1 chk("to_fetch14", state, S_FETCH);
    step(); #1 chk("to_halt", {state, fault, halted, mem_req}, {S_HALT, 2'd2, 1'b1, 1'b0});
    chk("to_instret", instret, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_ctrl.md
# riscv_multicycle_ctrl

Multi-cycle control unit for the RISC-V simple datapath. It sequences fetch, decode, execute, memory and writeback for an RV32I subset: LUI, JAL, BEQ/BNE, loads, stores, OP-IMM, OP and EBREAK. It drives every datapath strobe and mux select, including `imm_sel` for the immediate generator. It also handshakes with a shared instruction/data memory port and keeps a retired-instruction counter.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: number of consecutive un-acknowledged request cycles before a fault. Legal range is 1..255.
- `INSTRET_W`, default 32: width of the retired-instruction counter.

Ports:
- `sysclk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instruction` in 32: current IR contents from the datapath.
- `alu_zero` in 1: ALU result == 0.
- `mem_ready` in 1: memory acknowledge.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = store.
- `mem_addr_sel` out 1: 0 = PC, 1 = ALU result.
- `ir_write` out 1: load IR from memory read data.
- `pc_write` out 1: update PC.
- `pc_src` out 2: 0 = PC+4, 1 = branch target, 2 = JAL target.
- `reg_write` out 1: register file write enable.
- `wb_sel` out 2: 0 = ALU, 1 = memory data, 2 = PC+4, 3 = immediate.
- `alu_src_b` out 1: 0 = rs2, 1 = immediate.
- `alu_op` out 4: ALU operation code.
- `imm_sel` out 3: 0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- `halted` out 1: controller is in HALT.
- `fault` out 2: 0 = none, 1 = illegal instruction, 2 = memory timeout, 3 = EBREAK.
- `state` out 3: debug view of the current state.
- `instret` out INSTRET_W: retired-instruction count.

## Operation
States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- **IDLE:** all strobes 0. Goes to FETCH on the next cycle.
- **FETCH:**
  - Drives `mem_req=1`, `mem_we=0`, `mem_addr_sel=0`.
  - In a cycle with `mem_ready=1`, pulses `ir_write` and goes to DECODE.
- **DECODE:**
  - Decodes `instruction[6:0]`, `funct3` and `funct7[5]`.
  - An unknown opcode, a branch `funct3` other than 000/001, or an OP with an illegal `funct7` goes to HALT with `fault=1`.
  - 1110011 with `instruction[20]=1` goes to HALT with `fault=3` and retires.
  - Otherwise goes to EXEC.
  - `imm_sel` and `alu_src_b` are valid from DECODE through WB.
- **EXEC:**
  - **Branch:** `alu_op=SUB`, `pc_write=1`. `pc_src=1` if taken (BEQ: `alu_zero`; BNE: `!alu_zero`), else 0. Retires, then FETCH.
  - **JAL:** `pc_src=2`, `pc_write=1`, `reg_write=1`, `wb_sel=2`. Retires, then FETCH.
  - **LUI:** `reg_write=1`, `wb_sel=3`, `pc_write=1`, `pc_src=0`. Retires, then FETCH.
  - **OP / OP-IMM:** goes to WB.
  - **Load / store:** `alu_op=ADD`, goes to MEM.
- **MEM:**
  - Drives `mem_req=1`, `mem_addr_sel=1`, `mem_we=` store.
  - On `mem_ready`, a store does `pc_write` (`pc_src=0`), retires and goes to FETCH.
  - On `mem_ready`, a load goes to WB.
- **WB:** `reg_write=1`, `wb_sel` = 1 for a load else 0, `pc_write=1`, `pc_src=0`. Retires, then FETCH.
- **HALT:** all strobes 0, `halted=1`. Stays in HALT until reset.

`alu_op` encoding:
- Codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
- OP: selected by `funct3` plus `funct7[5]`.
- OP-IMM: `funct7[5]` is honoured only when `funct3=101`; there is no SUBI.

Register writes to rd=x0 still assert `reg_write`; the register file discards them.

## Timing
- **Reset:**
  - `rst_n` low forces IDLE immediately.
  - All outputs reset to 0: strobes, `fault`, `halted`, `instret`. `state` reads IDLE.
  - Reset in any state, including mid-MEM with `mem_req` high, drops `mem_req` within the same cycle.
- **Outputs:** strobes are combinational from state plus decoded IR (Moore style, except the `mem_ready`-gated `ir_write`/`pc_write` in FETCH/MEM). Retire increments `instret` on the clock edge that leaves the retiring state.
- **Handshake:**
  - `mem_req` holds high, with stable `mem_we`/`mem_addr_sel`, until the cycle in which `mem_ready=1`. That cycle completes the transfer.
  - `mem_ready` outside FETCH/MEM is ignored.
- **Timeout:**
  - An 8-bit wait counter clears on entry to FETCH/MEM and increments each cycle with `mem_ready=0`.
  - When it reaches `MEM_TIMEOUT`, the next state is HALT with `fault=2`.
  - `mem_ready=1` in that same cycle wins: the transfer completes and there is no fault.
- **Latency** with zero-wait memory:
  - Branch, JAL, LUI: 3 cycles.
  - OP, OP-IMM, store: 4 cycles.
  - Load: 5 cycles.
  - Each memory wait state adds 1 cycle.
- **`instret` wrap:** wraps modulo 2^INSTRET_W.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - opcode constants;
  - `alu_op`, `imm_sel`, `pc_src`, `wb_sel`, `fault` and state encodings.
- Both this block and the immediate generator use the `imm_sel` codes from the package.
- Sub-module `riscv_ctrl_decode` is purely combinational: IR in; instruction class, `alu_op`, `imm_sel` and illegal flag out.
- The top level contains the FSM, the wait counter and the `instret` counter.

## Test plan
- IR=0x02a00293 (addi x5,x0,42), zero-wait memory:
  - FETCH→DECODE→EXEC→WB in 4 cycles.
  - `imm_sel=0`, `alu_src_b=1`, `alu_op=ADD`.
  - `reg_write=1`, `wb_sel=0` in WB; `instret` goes 0→1.
- IR=0x00052283 (lw x5,0(x10)), 2 wait states in MEM:
  - `mem_req`, `mem_addr_sel=1`, `mem_we=0` held for 3 cycles.
  - WB with `wb_sel=1`; total 7 cycles.
- IR=0x01c38463 (beq, +8):
  - `alu_zero=1` → EXEC has `pc_write=1`, `pc_src=1`, `imm_sel=2`.
  - `alu_zero=0` → `pc_src=0`.
  - Neither case asserts `reg_write`.
- IR=0x006283b3 (add x7,x5,x6) → `alu_src_b=0`, `alu_op=ADD`. IR=0x406283b3 → `alu_op=SUB`.
- Fault and halt cases:
  - IR=0xffffffff → HALT, `fault=1`, `halted=1`, `instret` unchanged, no further `mem_req`.
  - `mem_ready` held 0 in FETCH for 15 cycles → HALT with `fault=2`.
  - IR=0x00100073 (EBREAK) → HALT with `fault=3`.
- Assert `rst_n=0` mid-MEM during a store:
  - `mem_req` and `mem_we` drop immediately; `instret=0`.
  - After release: IDLE for 1 cycle, then FETCH.
